fifo_arb_ctrl: RTL and testbench
================================

Name: fifo_arb_ctrl

Overview:
- Controller that shares the single-port-write 8-bit FIFO between two producers and sequences reads for one consumer.
- Arbitrates two write requesters round-robin and drives the FIFO's wr/din pins.
- Converts consumer read requests into FIFO rd strobes with a fixed-latency data-valid acknowledge.
- Keeps its own occupancy count so full/empty are known without decoding the FIFO's wrptr/rdptr.

Parameters:
- DW, 8, data width of producer and FIFO data.
- AW, 4, FIFO address width; depth = 2**AW = 16.
- RD_LAT, 1, cycles from fifo_rd high to valid data on the FIFO's dout.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  producer 0 write request, level.
- din0  in  DW  producer 0 data, stable while req0 high.
- gnt0  out  1  producer 0 grant, 1-cycle pulse; data taken this cycle.
- req1  in  1  producer 1 write request.
- din1  in  DW  producer 1 data.
- gnt1  out  1  producer 1 grant pulse.
- rd_req  in  1  consumer read request, level.
- rd_ack  out  1  pulse; FIFO dout valid this cycle.
- fifo_din  out  DW  to FIFO din.
- fifo_wr  out  1  to FIFO wr.
- fifo_rd  out  1  to FIFO rd.
- count  out  AW+1  occupancy, 0..16.
- full  out  1  count == 2**AW.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, async): gnt0=gnt1=0, fifo_wr=0, fifo_rd=0, fifo_din=0, rd_ack=0, count=0, empty=1, full=0, rr pointer favours producer 0, read FSM in R_IDLE.
- All outputs are registered.
- Write arbitration, evaluated every cycle:
  - If no gnt was issued last cycle and !full and (req0|req1), grant one requester.
  - Round-robin: the last-granted producer loses a tie. rr pointer updates only on a grant.
  - On grant: gntX=1, fifo_wr=1, fifo_din=dinX, all in the same registered cycle. Next cycle gnt and fifo_wr return to 0 (mandatory gap cycle).
  - Max write rate is one per 2 cycles.
  - A producer must drop reqX on the cycle after seeing gntX; a request held longer is granted again.
  - full blocks all grants. Requests wait, are never lost, and are never granted while full.
- Read FSM, states R_IDLE -> R_WAIT -> R_ACK -> R_IDLE:
  - R_IDLE: if rd_req && !empty, assert fifo_rd for 1 cycle and go to R_WAIT. If empty, remain in R_IDLE (request stalls).
  - R_WAIT: count RD_LAT cycles, then rd_ack=1 for 1 cycle (R_ACK), then return to R_IDLE.
  - One read in flight maximum. Consumer drops rd_req after rd_ack.
- Occupancy:
  - count +1 on fifo_wr, -1 on fifo_rd; simultaneous wr and rd leave count unchanged.
  - Decisions use the registered count plus any strobe issued the same cycle, so count never exceeds 16 or goes below 0.
  - full/empty derive from the next count, registered.
- Wrap-around is handled by the FIFO pointers. count has one extra bit to distinguish 16 from 0.
- Reset mid-operation aborts any grant or read, clears count, and returns all outputs to their reset values. The FIFO must be reset by the same rst.

Optional Feature:
- FIFO_ARB_PRIO_EN defined: fixed priority, producer 0 always wins ties. rr pointer is removed.
- FIFO_ARB_PRIO_EN undefined: round-robin as above (default).

Test Plan:
- Reset then idle: rst low 2 cycles -> count=0, empty=1, full=0, all strobes 0. Asserting rst low mid-write clears count immediately.
- Single producer: req0 with din0=8'h24 -> gnt0 and fifo_wr pulse 1 cycle with fifo_din=8'h24; count=1, empty=0.
- Contention: req0 and req1 held continuously -> grants alternate gnt0, gnt1, gnt0, ... with 1 idle cycle between grants. With FIFO_ARB_PRIO_EN -> gnt0 only.
- Fill: 16 single writes -> count=16, full=1. A 17th req1 waits with no gnt1 until a read completes, then gnt1 issues and count returns to 16.
- Drain: 16 rd_req with RD_LAT=1 -> each fifo_rd is followed by rd_ack exactly 2 cycles later. Data order equals write order. After the last read, empty=1; a further rd_req stalls with no fifo_rd.
- Simultaneous: count=5, a grant and fifo_rd issued in the same cycle -> count stays 5.

Source files
------------

// File: rtl/fifo_arb_ctrl.sv
// Two-producer round-robin write arbiter and fixed-latency read sequencer for a 16-deep FIFO.
// Build option: define FIFO_ARB_PRIO_EN for fixed priority (producer 0 wins ties).
module fifo_arb_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [DW-1:0] din0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] din1,
  output logic          gnt1,
  input  logic          rd_req,
  output logic          rd_ack,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wr,
  output logic          fifo_rd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [1:0]    R_IDLE   = 2'd0;
  localparam logic [1:0]    R_WAIT   = 2'd1;
  localparam logic [1:0]    R_ACK    = 2'd2;
  localparam int            LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(2**AW);

  logic [1:0]    state;
  logic [LW-1:0] lat;
  logic          grant_ok;
  logic          pick0;
  logic          pick1;
  logic          wr_nxt;
  logic          rd_nxt;
  logic [AW:0]   count_nxt;

`ifdef FIFO_ARB_PRIO_EN
  always_comb begin
    pick0 = req0;
    pick1 = req1 && !req0;
  end
`else
  // prefer1 set means producer 1 wins the next tie (producer 0 was granted last).
  logic prefer1;

  always_comb begin
    pick1 = req1 && (!req0 || prefer1);
    pick0 = req0 && !pick1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        prefer1 <= 1'b0;
    else if (wr_nxt) prefer1 <= pick0;
  end
`endif

  // A grant in the previous cycle forces a gap cycle; full blocks all grants.
  always_comb begin
    grant_ok = !(gnt0 || gnt1) && !full;
    wr_nxt   = grant_ok && (req0 || req1);
    rd_nxt   = (state == R_IDLE) && rd_req && !empty;
    case ({wr_nxt, rd_nxt})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
    end else begin
      gnt0    <= grant_ok && pick0;
      gnt1    <= grant_ok && pick1;
      fifo_wr <= wr_nxt;
      if (grant_ok && pick0)      fifo_din <= din0;
      else if (grant_ok && pick1) fifo_din <= din1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == DEPTH);
      empty <= (count_nxt == '0);
    end
  end

  // Read sequencer: rd strobe, RD_LAT wait cycles, then one ack cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= R_IDLE;
      lat     <= '0;
      fifo_rd <= 1'b0;
      rd_ack  <= 1'b0;
    end else begin
      fifo_rd <= rd_nxt;
      rd_ack  <= (state == R_ACK);
      case (state)
        R_IDLE: begin
          lat <= '0;
          if (rd_nxt) state <= R_WAIT;
        end
        R_WAIT: begin
          if (lat == LAT_LAST) state <= R_ACK;
          else                 lat   <= lat + LW'(1);
        end
        R_ACK:   state <= R_IDLE;
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl: vector table plus fill/drain/reset sequences against a small FIFO model.
module tb_fifo_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rd_req;
  logic [7:0] din0, din1;
  logic       gnt0, gnt1, rd_ack, fifo_wr, fifo_rd, full, empty;
  logic [7:0] fifo_din;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

`ifdef FIFO_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_arb_ctrl #(.DW(8), .AW(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .din0(din0), .gnt0(gnt0),
    .req1(req1), .din1(din1), .gnt1(gnt1),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .count(count), .full(full), .empty(empty)
  );

  // Behavioural 16-deep FIFO with one cycle read latency, sharing rst.
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [7:0] dout;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0; rp <= '0; dout <= '0;
    end else begin
      if (fifo_wr) begin mem[wp] <= fifo_din; wp <= wp + 4'd1; end
      if (fifo_rd) begin dout <= mem[rp]; rp <= rp + 4'd1; end
    end
  end

  logic [7:0] exp_q [$];

  typedef struct {
    logic       r0; logic [7:0] d0;
    logic       r1; logic [7:0] d1;
    logic       rr;
    logic       g0, g1, wr;
    logic [7:0] fd;
    logic       frd, ack;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(logic r0, logic [7:0] d0, logic r1, logic [7:0] d1, logic rr,
                              logic g0, logic g1, logic wr, logic [7:0] fd,
                              logic frd, logic ack, logic [4:0] cnt);
    vec_t v;
    v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.rr = rr;
    v.g0 = g0; v.g1 = g1; v.wr = wr; v.fd = fd;
    v.frd = frd; v.ack = ack; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_ack) begin
      if (exp_q.size() == 0) chk("rd_data_unexpected_ack", 32'd1, 32'd0);
      else                   chk("rd_data", {24'd0, dout}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    rst = 1'b0; req0 = 0; req1 = 0; rd_req = 0; din0 = '0; din1 = '0;

    // Expected outputs per cycle: r0 d0 r1 d1 rd | g0 g1 wr fifo_din rd ack count
    tbl[0]  = mk(1, 8'h24, 0, 8'h00, 0,  1, 0, 1, 8'h24, 0, 0, 5'd1);
    tbl[1]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h24, 0, 0, 5'd1);
    tbl[2]  = PRIO ? mk(1, 8'h11, 1, 8'h22, 0,  1, 0, 1, 8'h11, 0, 0, 5'd2)
                   : mk(1, 8'h11, 1, 8'h22, 0,  0, 1, 1, 8'h22, 0, 0, 5'd2);
    tbl[3]  = PRIO ? mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 0, 8'h11, 0, 0, 5'd2)
                   : mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 0, 8'h22, 0, 0, 5'd2);
    tbl[4]  = mk(1, 8'h11, 1, 8'h22, 0,  1, 0, 1, 8'h11, 0, 0, 5'd3);
    tbl[5]  = mk(1, 8'h11, 1, 8'h22, 0,  0, 0, 0, 8'h11, 0, 0, 5'd3);
    tbl[6]  = PRIO ? mk(1, 8'h11, 1, 8'h22, 0,  1, 0, 1, 8'h11, 0, 0, 5'd4)
                   : mk(1, 8'h11, 1, 8'h22, 0,  0, 1, 1, 8'h22, 0, 0, 5'd4);
    tbl[7]  = PRIO ? mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h11, 0, 0, 5'd4)
                   : mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h22, 0, 0, 5'd4);
    tbl[8]  = mk(1, 8'h55, 0, 8'h00, 0,  1, 0, 1, 8'h55, 0, 0, 5'd5);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h55, 0, 0, 5'd5);
    tbl[10] = mk(0, 8'h00, 1, 8'h66, 1,  0, 1, 1, 8'h66, 1, 0, 5'd5);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h66, 0, 0, 5'd5);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h66, 0, 1, 5'd5);
    tbl[13] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'h66, 0, 0, 5'd5);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_fifo_din", fifo_din, 0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      req0 = tbl[i].r0; din0 = tbl[i].d0;
      req1 = tbl[i].r1; din1 = tbl[i].d1;
      rd_req = tbl[i].rr;
      tick();
      if (tbl[i].wr) exp_q.push_back(tbl[i].fd);
      chk($sformatf("row%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("row%0d_gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("row%0d_fifo_wr", i), fifo_wr, tbl[i].wr);
      chk($sformatf("row%0d_fifo_din", i), fifo_din, tbl[i].fd);
      chk($sformatf("row%0d_fifo_rd", i), fifo_rd, tbl[i].frd);
      chk($sformatf("row%0d_rd_ack", i), rd_ack, tbl[i].ack);
      chk($sformatf("row%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("row%0d_empty", i), empty, tbl[i].cnt == 0);
      chk($sformatf("row%0d_full", i), full, tbl[i].cnt == 16);
    end

    // Reset asserted in the middle of a write cycle.
    req0 = 1; din0 = 8'h77;
    tick();
    chk("midrst_pre_gnt0", gnt0, 1);
    chk("midrst_pre_count", count, 6);
    rst = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_gnt0", gnt0, 0);
    chk("midrst_fifo_wr", fifo_wr, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_fifo_din", fifo_din, 0);
    req0 = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Fill to 16 with single producer 0 writes.
    for (int i = 0; i < 16; i++) begin
      req0 = 1; din0 = 8'h80 + 8'(i);
      tick();
      chk($sformatf("fill%0d_gnt0", i), gnt0, 1);
      chk($sformatf("fill%0d_count", i), count, i + 1);
      exp_q.push_back(8'h80 + 8'(i));
      req0 = 0;
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);

    // A 17th request waits while full.
    req1 = 1; din1 = 8'hA5;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("blocked%0d_gnt1", i), gnt1, 0);
      chk($sformatf("blocked%0d_fifo_wr", i), fifo_wr, 0);
    end
    rd_req = 1;
    tick();
    chk("unblock_fifo_rd", fifo_rd, 1);
    chk("unblock_count15", count, 15);
    rd_req = 0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (gnt1) got = 1'b1;
    end
    chk("unblock_gnt1_seen", got, 1);
    chk("unblock_count16", count, 16);
    chk("unblock_fifo_din", fifo_din, 8'hA5);
    exp_q.push_back(8'hA5);
    req1 = 0;
    repeat (3) tick();

    // Drain: ack exactly two cycles after each rd strobe, data in write order.
    for (int i = 0; i < 16; i++) begin
      rd_req = 1;
      tick();
      chk($sformatf("drain%0d_fifo_rd", i), fifo_rd, 1);
      rd_req = 0;
      tick();
      chk($sformatf("drain%0d_ack_early", i), rd_ack, 0);
      tick();
      chk($sformatf("drain%0d_ack", i), rd_ack, 1);
      tick();
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_queue_used", exp_q.size(), 0);

    rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall%0d_fifo_rd", i), fifo_rd, 0);
    end
    rd_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
